// File: rtl/line_framer_if.sv
// Stream bundle for line_framer: unframed pixel input and framed pixel output.
// The framer owns the slave modport; its upstream/downstream partner owns master.
interface line_framer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_line_end;
    logic                  out_frame_start;
    logic                  out_frame_end;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid,
        input  out_line_end,
        input  out_frame_start,
        input  out_frame_end
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid,
        output out_line_end,
        output out_frame_start,
        output out_frame_end
    );
endinterface

// File: rtl/line_framer.sv
// Transmit-side framer: tags a raw pixel stream with frame-start, line-end and
// frame-end markers from the width/height captured at start, and optionally
// idles for a programmable number of cycles after every non-final line.
// Optional build macro LINE_FRAMER_ABORT_EN adds an 'abort' input that forces
// the framer back to IDLE and discards the output beat.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start with non-zero width and height
// ACTIVE | accepting pixels; in_ready follows the output register
// BLANK  | inter-line gap, input stalled, output register still drains
module line_framer #(
    parameter int WIDTH       = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int BLANK_WIDTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       width,
    input  logic [WIDTH-1:0]       height,
    input  logic [BLANK_WIDTH-1:0] blank,
    input  logic                   start,
`ifdef LINE_FRAMER_ABORT_EN
    input  logic                   abort,
`endif
    line_framer_if.slave           bus,
    output logic                   busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_BLANK  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]       W_ONE = WIDTH'(1);
    localparam logic [BLANK_WIDTH-1:0] B_ONE = BLANK_WIDTH'(1);

    state_t                  r_state;
    logic [WIDTH-1:0]        r_col;
    logic [WIDTH-1:0]        r_row;
    logic [WIDTH-1:0]        r_width_l;
    logic [WIDTH-1:0]        r_height_l;
    logic [BLANK_WIDTH-1:0]  r_blank_l;
    logic [BLANK_WIDTH-1:0]  r_blank_cnt;

    logic [DATA_WIDTH-1:0]   r_out_data;
    logic                    r_out_valid;
    logic                    r_out_line_end;
    logic                    r_out_frame_start;
    logic                    r_out_frame_end;

    logic                    w_abort;
    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_line_end;
    logic                    w_frame_end;
    logic                    w_start_ok;

`ifdef LINE_FRAMER_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Input is taken only while ACTIVE and the output slot is free or emptying.
    assign w_in_ready  = (r_state == S_ACTIVE) && (!r_out_valid || bus.out_ready) && !w_abort;
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_line_end  = (r_col == (r_width_l - W_ONE));
    assign w_frame_end = w_line_end && (r_row == (r_height_l - W_ONE));
    assign w_start_ok  = start && (width != '0) && (height != '0);

    // Sequencing FSM with the column/row position and blanking down-counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_width_l   <= '0;
            r_height_l  <= '0;
            r_blank_l   <= '0;
            r_blank_cnt <= '0;
        end else if (w_abort) begin
            r_state     <= S_IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_blank_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_width_l  <= width;
                        r_height_l <= height;
                        r_blank_l  <= blank;
                        r_col      <= '0;
                        r_row      <= '0;
                        r_state    <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (w_accept) begin
                        if (w_frame_end) begin
                            r_col   <= '0;
                            r_row   <= '0;
                            r_state <= S_IDLE;
                        end else if (w_line_end) begin
                            r_col <= '0;
                            r_row <= r_row + W_ONE;
                            if (r_blank_l != '0) begin
                                r_blank_cnt <= r_blank_l;
                                r_state     <= S_BLANK;
                            end
                        end else begin
                            r_col <= r_col + W_ONE;
                        end
                    end
                end
                S_BLANK: begin
                    // Leaving on a count of 1 makes the gap exactly r_blank_l cycles.
                    if (r_blank_cnt <= B_ONE) begin
                        r_blank_cnt <= '0;
                        r_state     <= S_ACTIVE;
                    end else begin
                        r_blank_cnt <= r_blank_cnt - B_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Single-entry output register: load on accept, hold on stall, clear when drained.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_data        <= '0;
            r_out_valid       <= 1'b0;
            r_out_line_end    <= 1'b0;
            r_out_frame_start <= 1'b0;
            r_out_frame_end   <= 1'b0;
        end else if (w_abort) begin
            r_out_valid       <= 1'b0;
            r_out_line_end    <= 1'b0;
            r_out_frame_start <= 1'b0;
            r_out_frame_end   <= 1'b0;
        end else if (w_accept) begin
            r_out_data        <= bus.in_data;
            r_out_valid       <= 1'b1;
            r_out_line_end    <= w_line_end;
            r_out_frame_start <= (r_col == '0) && (r_row == '0);
            r_out_frame_end   <= w_frame_end;
        end else if (bus.out_ready) begin
            r_out_valid       <= 1'b0;
            r_out_line_end    <= 1'b0;
            r_out_frame_start <= 1'b0;
            r_out_frame_end   <= 1'b0;
        end
    end

    assign bus.in_ready        = w_in_ready;
    assign bus.out_data        = r_out_data;
    assign bus.out_valid       = r_out_valid;
    assign bus.out_line_end    = r_out_line_end;
    assign bus.out_frame_start = r_out_frame_start;
    assign bus.out_frame_end   = r_out_frame_end;
    assign busy                = (r_state != S_IDLE) || r_out_valid;

endmodule

// File: tb/tb_line_framer.sv
// Self-checking bench for line_framer. The reference model tracks the frame as
// a pixel index (col = idx % width, row = idx / width) plus a queue of beats
// owed downstream; it is checked against the DUT every cycle.
module tb_line_framer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] width = '0;
    logic [7:0] height = '0;
    logic [3:0] blank = '0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       busy;

    line_framer_if #(.DATA_WIDTH(8)) bus ();

    line_framer #(.WIDTH(8), .DATA_WIDTH(8), .BLANK_WIDTH(4)) dut (
        .clock  (clock),
        .reset  (reset),
        .width  (width),
        .height (height),
        .blank  (blank),
        .start  (start),
`ifdef LINE_FRAMER_ABORT_EN
        .abort  (abort),
`endif
        .bus    (bus),
        .busy   (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] d;
        logic       fs;
        logic       le;
        logic       fe;
    } beat_t;

    beat_t q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    n_obs = 0;
    bit    in_frame = 0;
    int    blank_left = 0;
    int    acc_idx = 0;
    int    mw = 0, mh = 0, mb = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        in_frame   = 0;
        blank_left = 0;
        acc_idx    = 0;
    endtask

    // One clock: check the settled outputs against the model, advance the model
    // by this edge, then wait for the next falling edge.
    task automatic tick();
        bit    exp_rdy;
        bit    start_ok;
        beat_t b;
        int    col;
        #1;
        exp_rdy  = in_frame && (blank_left == 0) && (q.size() == 0 || bus.out_ready) && !abort;
        start_ok = start && !in_frame && (width != 0) && (height != 0) && !abort;
        chk("in_ready", bus.in_ready, exp_rdy);
        chk("out_valid", bus.out_valid, q.size() != 0);
        chk("busy", busy, in_frame || q.size() != 0);
        if (q.size() != 0) begin
            chk("out_data", bus.out_data, q[0].d);
            chk("frame_start", bus.out_frame_start, q[0].fs);
            chk("line_end", bus.out_line_end, q[0].le);
            chk("frame_end", bus.out_frame_end, q[0].fe);
        end else begin
            chk("idle_markers", {bus.out_frame_start, bus.out_line_end, bus.out_frame_end}, 0);
        end
        if (bus.out_valid && bus.out_ready) n_obs++;

        if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
        if (abort) begin
            model_clear();
        end else begin
            if (blank_left > 0) blank_left--;
            if (exp_rdy && bus.in_valid) begin
                col  = acc_idx % mw;
                b.d  = bus.in_data;
                b.fs = (acc_idx == 0);
                b.le = (col == mw - 1);
                b.fe = (acc_idx == mw * mh - 1);
                q.push_back(b);
                acc_idx++;
                if (b.fe) in_frame = 0;
                else if (b.le && mb != 0) blank_left = mb;
            end
            if (start_ok) begin
                mw       = width;
                mh       = height;
                mb       = blank;
                acc_idx  = 0;
                in_frame = 1;
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input int pv, input int pr);
        bus.in_valid  = ($urandom_range(99) < pv);
        bus.out_ready = ($urandom_range(99) < pr);
        bus.in_data   = 8'($urandom);
    endtask

    // Start a frame, scramble the config inputs, then stream until the model
    // and the DUT are both idle. out_ready is forced low for 5 ticks from stall_at.
    task automatic run_frame(input int w, input int h, input int bl,
                             input int pv, input int pr, input int stall_at);
        int k;
        int obs0;
        obs0   = n_obs;
        width  = 8'(w);
        height = 8'(h);
        blank  = 4'(bl);
        start  = 1'b1;
        drive(pv, pr);
        tick();
        start  = 1'b0;
        width  = 8'($urandom);
        height = 8'($urandom);
        blank  = 4'($urandom);
        k = 1;
        while ((in_frame || q.size() != 0) && k < 2000) begin
            drive(pv, pr);
            if (k >= stall_at && k < stall_at + 5) bus.out_ready = 1'b0;
            tick();
            k++;
        end
        #1;
        chk("frame_done_busy", busy, 0);
        chk("beat_count", n_obs - obs0, w * h);
        @(negedge clock);
    endtask

    initial begin
        int k;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_data   = '0;
        model_clear();

        // Held in reset: everything idle.
        @(negedge clock);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Back-to-back 4x2 frame, no blanking.
        run_frame(4, 2, 0, 100, 100, 9999);

        // 3x3 with two blanking cycles after each non-final line.
        run_frame(3, 3, 2, 100, 100, 9999);

        // 4x1 with a 5-cycle downstream stall right after the first beat.
        run_frame(4, 1, 0, 100, 100, 2);

        // Zero width start is ignored, then a 2x1 frame.
        width  = 8'd0;
        height = 8'd5;
        start  = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        run_frame(2, 1, 0, 100, 100, 9999);

        // Reset mid-line after two of four beats.
        width  = 8'd4;
        height = 8'd2;
        blank  = 4'd0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        model_clear();
        @(negedge clock);
        reset = 1'b1;
        run_frame(4, 2, 1, 100, 100, 9999);

`ifdef LINE_FRAMER_ABORT_EN
        // Abort while blanking, then a clean frame.
        width  = 8'd3;
        height = 8'd2;
        blank  = 4'd4;
        start  = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (blank_left == 0 && k < 20) begin
            tick();
            k++;
        end
        chk("abort_reached_blank", dut.busy && !bus.in_ready, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        chk("abort_busy", busy, 0);
        run_frame(3, 2, 1, 100, 100, 9999);
`endif

        // Randomised frames with random valid/ready pressure.
        for (int f = 0; f < 8; f++) begin
            run_frame(int'($urandom_range(1, 6)), int'($urandom_range(1, 4)),
                      int'($urandom_range(0, 3)), int'($urandom_range(40, 100)),
                      int'($urandom_range(40, 100)), 9999);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
